// File: rtl/ibex_mem_arb_pkg.sv
// ibex_mem_arb_pkg: shared owner type and limits for the instr/data memory arbiter
package ibex_mem_arb_pkg;
  typedef enum logic {OwnerInstr = 1'b0, OwnerData = 1'b1} owner_e;
  localparam int unsigned ArbMaxOutstandingLimit = 4;
endpackage

// File: rtl/ibex_mem_arb_owner_fifo.sv
// ibex_mem_arb_owner_fifo: circular FIFO recording which port owns each outstanding transaction
module ibex_mem_arb_owner_fifo
  import ibex_mem_arb_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   push_i,
  input  owner_e wdata_i,
  input  logic   pop_i,
  output logic   full_o,
  output logic   empty_o,
  output owner_e head_o
);
  localparam int unsigned PtrW = Depth > 1 ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);
  owner_e mem_q [Depth];
  logic [PtrW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  always_comb begin
    wr_d = push_i ? (wr_q == PtrW'(Depth - 1) ? '0 : wr_q + 1'b1) : wr_q;
    rd_d = pop_i ? (rd_q == PtrW'(Depth - 1) ? '0 : rd_q + 1'b1) : rd_q;
    cnt_d = cnt_q + CntW'(push_i) - CntW'(pop_i);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_q] <= wdata_i;
  end
  assign full_o  = cnt_q == CntW'(Depth);
  assign empty_o = cnt_q == '0;
  assign head_o  = mem_q[rd_q];
endmodule

// File: rtl/ibex_mem_arbiter.sv
// ibex_mem_arbiter: merges instr and data request ports onto one memory port, routing responses by owner.
// IBEX_MEM_ARB_PERF_EN adds saturating per-port stall counters.
module ibex_mem_arbiter
  import ibex_mem_arb_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 2,
  parameter bit          DataPriority   = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        instr_req_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  input  logic [31:0] instr_addr_i,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_err_i
`ifdef IBEX_MEM_ARB_PERF_EN
  ,
  output logic [31:0] perf_instr_stall_o,
  output logic [31:0] perf_data_stall_o
`endif
);
  owner_e sel, lock_owner_q, head;
  logic lock_q, lock_d, rr_q, fifo_full, fifo_empty, push, pop, sel_data;
  // rr_q set means data is preferred on the next contended cycle
  always_comb begin
    sel = OwnerInstr;
    if (lock_q) sel = lock_owner_q;
    else if (DataPriority || !(instr_req_i && data_req_i)) sel = data_req_i ? OwnerData : OwnerInstr;
    else sel = rr_q ? OwnerData : OwnerInstr;
  end
  assign sel_data    = sel == OwnerData;
  assign mem_req_o   = (instr_req_i | data_req_i) & ~fifo_full;
  assign push        = mem_req_o & mem_gnt_i;
  assign pop         = mem_rvalid_i & ~fifo_empty;
  assign lock_d      = mem_req_o & ~mem_gnt_i;
  assign mem_we_o    = sel_data ? data_we_i : 1'b0;
  assign mem_be_o    = sel_data ? data_be_i : 4'hF;
  assign mem_addr_o  = sel_data ? data_addr_i : instr_addr_i;
  assign mem_wdata_o = sel_data ? data_wdata_i : 32'h0;
  assign instr_gnt_o = push & ~sel_data;
  assign data_gnt_o  = push & sel_data;
  assign instr_rvalid_o = pop & (head == OwnerInstr);
  assign data_rvalid_o  = pop & (head == OwnerData);
  assign instr_err_o    = instr_rvalid_o & mem_err_i;
  assign data_err_o     = data_rvalid_o & mem_err_i;
  assign instr_rdata_o  = mem_rdata_i;
  assign data_rdata_o   = mem_rdata_i;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lock_q       <= 1'b0;
      lock_owner_q <= OwnerInstr;
      rr_q         <= 1'b0;
    end else begin
      lock_q       <= lock_d;
      lock_owner_q <= sel;
      if (push) rr_q <= sel == OwnerInstr;
    end
  end
  ibex_mem_arb_owner_fifo #(.Depth(MaxOutstanding)) u_owner_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .wdata_i (sel),
    .pop_i   (pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (head)
  );
  a_no_orphan_rvalid: assert property (@(posedge clk_i) disable iff (rst_i) !(mem_rvalid_i && fifo_empty));
`ifdef IBEX_MEM_ARB_PERF_EN
  logic [31:0] perf_instr_q, perf_data_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_instr_q <= '0;
      perf_data_q  <= '0;
    end else begin
      if (instr_req_i && !instr_gnt_o && perf_instr_q != '1) perf_instr_q <= perf_instr_q + 1'b1;
      if (data_req_i && !data_gnt_o && perf_data_q != '1) perf_data_q <= perf_data_q + 1'b1;
    end
  end
  assign perf_instr_stall_o = perf_instr_q;
  assign perf_data_stall_o  = perf_data_q;
`endif
endmodule

// File: tb/tb_ibex_mem_arbiter.sv
// tb_ibex_mem_arbiter: directed scoreboard bench for the priority and round-robin arbiter builds
module tb_ibex_mem_arbiter;
  import ibex_mem_arb_pkg::*;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic instr_req, data_req, data_we, mem_gnt, mem_rvalid, mem_err;
  logic [31:0] instr_addr, data_addr, data_wdata, mem_rdata;
  logic [3:0] data_be;
  logic i_gnt, i_rv, i_err, d_gnt, d_rv, d_err, m_req, m_we;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
  logic [3:0] m_be;
  logic r_igr, r_irv, r_ierr, r_dgr, r_drv, r_derr, r_req, r_we;
  logic [31:0] r_irdata, r_drdata, r_addr, r_wdata;
  logic [3:0] r_be;
`ifdef IBEX_MEM_ARB_PERF_EN
  logic [31:0] p_instr, p_data, rp_instr, rp_data;
`endif
  typedef struct packed {logic owner; logic [31:0] rdata; logic err;} exp_t;
  exp_t exp_q[$];
  int checks = 0, errors = 0;

  ibex_mem_arbiter #(.MaxOutstanding(2), .DataPriority(1'b1)) u_dut (
    .clk_i(clk), .rst_i(rst),
    .instr_req_i(instr_req), .instr_gnt_o(i_gnt), .instr_rvalid_o(i_rv), .instr_addr_i(instr_addr),
    .instr_rdata_o(i_rdata), .instr_err_o(i_err),
    .data_req_i(data_req), .data_gnt_o(d_gnt), .data_rvalid_o(d_rv), .data_we_i(data_we), .data_be_i(data_be),
    .data_addr_i(data_addr), .data_wdata_i(data_wdata), .data_rdata_o(d_rdata), .data_err_o(d_err),
    .mem_req_o(m_req), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid), .mem_we_o(m_we), .mem_be_o(m_be),
    .mem_addr_o(m_addr), .mem_wdata_o(m_wdata), .mem_rdata_i(mem_rdata), .mem_err_i(mem_err)
`ifdef IBEX_MEM_ARB_PERF_EN
    , .perf_instr_stall_o(p_instr), .perf_data_stall_o(p_data)
`endif
  );

  ibex_mem_arbiter #(.MaxOutstanding(2), .DataPriority(1'b0)) u_rr (
    .clk_i(clk), .rst_i(rst),
    .instr_req_i(instr_req), .instr_gnt_o(r_igr), .instr_rvalid_o(r_irv), .instr_addr_i(instr_addr),
    .instr_rdata_o(r_irdata), .instr_err_o(r_ierr),
    .data_req_i(data_req), .data_gnt_o(r_dgr), .data_rvalid_o(r_drv), .data_we_i(data_we), .data_be_i(data_be),
    .data_addr_i(data_addr), .data_wdata_i(data_wdata), .data_rdata_o(r_drdata), .data_err_o(r_derr),
    .mem_req_o(r_req), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid), .mem_we_o(r_we), .mem_be_o(r_be),
    .mem_addr_o(r_addr), .mem_wdata_o(r_wdata), .mem_rdata_i(mem_rdata), .mem_err_i(mem_err)
`ifdef IBEX_MEM_ARB_PERF_EN
    , .perf_instr_stall_o(rp_instr), .perf_data_stall_o(rp_data)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    mem_err = 1'b0;
    mem_rdata = 32'h0;
  endtask

  task automatic push_exp(input logic o, input logic [31:0] d, input logic e);
    exp_t x;
    x.owner = o;
    x.rdata = d;
    x.err = e;
    exp_q.push_back(x);
  endtask

  // memory model: return the next planned response and check where it lands
  task automatic resp();
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL sb_empty observed=0 expected=nonempty");
      return;
    end
    e = exp_q.pop_front();
    mem_rvalid = 1'b1;
    mem_rdata = e.rdata;
    mem_err = e.err;
    #1;
    chk("instr_rvalid", i_rv, !e.owner);
    chk("data_rvalid", d_rv, e.owner);
    chk("instr_err", i_err, !e.owner && e.err);
    chk("data_err", d_err, e.owner && e.err);
    chk("instr_rdata", i_rdata, e.rdata);
    chk("data_rdata", d_rdata, e.rdata);
  endtask

  initial begin
    instr_req = 0; data_req = 0; data_we = 0; data_be = 0; instr_addr = 0; data_addr = 0; data_wdata = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_err = 0; mem_rdata = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    step(); #1;
    chk("rst_mem_req", m_req, 0); chk("rst_igr", i_gnt, 0); chk("rst_dgr", d_gnt, 0);
    chk("rst_irv", i_rv, 0); chk("rst_drv", d_rv, 0); chk("rst_ierr", i_err, 0); chk("rst_derr", d_err, 0);
    // instr only: granted after two stalled cycles, response one cycle later
    step(); instr_req = 1; instr_addr = 32'h100; data_we = 1; data_be = 4'h3; data_wdata = 32'hCAFE_F00D; #1;
    chk("i_req", m_req, 1); chk("i_addr", m_addr, 32'h100); chk("i_be", m_be, 4'hF);
    chk("i_we", m_we, 0); chk("i_wdata", m_wdata, 0); chk("i_gnt_wait", i_gnt, 0);
    step(); #1; chk("i_gnt_wait2", i_gnt, 0); chk("i_addr2", m_addr, 32'h100);
    step(); mem_gnt = 1; #1; chk("i_gnt", i_gnt, 1); chk("i_dgnt", d_gnt, 0);
    push_exp(OwnerInstr, 32'hDEAD_BEEF, 0);
    step(); instr_req = 0; resp(); chk("idle_req", m_req, 0);
    // contention: priority build picks data, round-robin build picks data after the instr grant
    step(); instr_req = 1; instr_addr = 32'h200; data_req = 1; data_addr = 32'h2000; data_wdata = 32'h1234; mem_gnt = 1; #1;
    chk("pri_dgnt", d_gnt, 1); chk("pri_igr", i_gnt, 0); chk("pri_addr", m_addr, 32'h2000);
    chk("pri_we", m_we, 1); chk("pri_be", m_be, 4'h3); chk("pri_wdata", m_wdata, 32'h1234);
    chk("rr_first_d", r_dgr, 1);
    push_exp(OwnerData, 32'hA5A5_0000, 0);
    for (int k = 0; k < 4; k++) begin
      step(); mem_gnt = 1; resp();
      chk("rr_igr", r_igr, (k % 2) == 0); chk("rr_dgr", r_dgr, (k % 2) == 1); chk("pri_hold_d", d_gnt, 1);
      push_exp(OwnerData, 32'hA5A5_0001 + k, 0);
    end
    step(); instr_req = 0; data_req = 0; resp();
    // lock: data shown first must stay on the bus until granted
    step(); data_req = 1; data_addr = 32'h2000; data_we = 0; data_be = 4'hF; #1; chk("lk_addr0", m_addr, 32'h2000);
    step(); instr_req = 1; instr_addr = 32'h300; #1;
    chk("lk_addr1", m_addr, 32'h2000); chk("lk_rr_addr1", r_addr, 32'h2000); chk("lk_igr", i_gnt, 0);
    step(); #1; chk("lk_addr2", m_addr, 32'h2000); chk("lk_rr_addr2", r_addr, 32'h2000);
    step(); mem_gnt = 1; #1; chk("lk_dgnt", d_gnt, 1); chk("lk_rr_dgnt", r_dgr, 1); chk("lk_addr3", m_addr, 32'h2000);
    push_exp(OwnerData, 32'hB000_0001, 0);
    step(); data_req = 0; mem_gnt = 1; #1; chk("lk_igr_after", i_gnt, 1); chk("lk_iaddr", m_addr, 32'h300);
    push_exp(OwnerInstr, 32'hB000_0002, 0);
    // full: no issue even with a same-cycle response, reissue on the next cycle
    step(); mem_gnt = 1; resp(); chk("full_req", m_req, 0); chk("full_igr", i_gnt, 0);
    step(); #1; chk("reissue_req", m_req, 1);
    step(); mem_gnt = 1; #1; chk("reissue_igr", i_gnt, 1);
    push_exp(OwnerInstr, 32'hB000_0003, 0);
    step(); instr_req = 0; resp();
    step(); resp();
    // interleaved I,D,I with an error on the data response
    step(); instr_req = 1; instr_addr = 32'h400; mem_gnt = 1; #1; chk("il_igr1", i_gnt, 1);
    push_exp(OwnerInstr, 32'hC000_0001, 0);
    step(); instr_req = 0; data_req = 1; data_addr = 32'h3000; mem_gnt = 1; #1; chk("il_dgr", d_gnt, 1);
    push_exp(OwnerData, 32'hC000_0002, 1);
    step(); data_req = 0; resp();
    step(); instr_req = 1; mem_gnt = 1; #1; chk("il_igr2", i_gnt, 1);
    push_exp(OwnerInstr, 32'hC000_0003, 0);
    step(); instr_req = 0; resp();
    step(); resp();
    // reset with two outstanding must empty the ownership FIFO
    step(); instr_req = 1; mem_gnt = 1;
    step(); instr_req = 0; data_req = 1; mem_gnt = 1;
    step(); data_req = 0; rst = 1; exp_q.delete();
    step(); rst = 0; #1; chk("mrst_irv", i_rv, 0); chk("mrst_drv", d_rv, 0); chk("mrst_req", m_req, 0);
    step(); instr_req = 1; mem_gnt = 1; #1; chk("mrst_req1", m_req, 1); chk("mrst_igr", i_gnt, 1);
    push_exp(OwnerInstr, 32'hD000_0001, 0);
    step(); instr_req = 0; data_req = 1; mem_gnt = 1; #1; chk("mrst_req2", m_req, 1); chk("mrst_dgr", d_gnt, 1);
    push_exp(OwnerData, 32'hD000_0002, 0);
    step(); data_req = 0; resp();
    step(); resp();
`ifdef IBEX_MEM_ARB_PERF_EN
    step(); rst = 1;
    step(); rst = 0; instr_req = 1;
    repeat (4) step();
    step(); #1; chk("perf_instr", p_instr, 5); chk("perf_data", p_data, 0);
    mem_gnt = 1;
    push_exp(OwnerInstr, 32'hE000_0001, 0);
    step(); instr_req = 0; resp();
    step(); #1; chk("perf_instr_hold", p_instr, 5);
`endif
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
